// File: rtl/pipe_track.sv
// Pipeline stage tracker: follows IR/PC/valid through decode..writeback, resolves
// load-use hazards, flushes on control transfers and counts retired instructions.
module pipe_track #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     STAGES      = 4,
  parameter int unsigned     FLUSH_STAGE = 1,
  parameter logic [XLEN-1:0] NOP         = 32'h00000013
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [XLEN-1:0]          IF_IR,
  input  logic [XLEN-1:0]          IF_PC,
  input  logic                     IF_VALID,
  input  logic                     FREEZE,
  input  logic                     FLUSH,
  input  logic                     STALL_REQ,
  output logic [STAGES*XLEN-1:0]   STAGE_IR,
  output logic [STAGES*XLEN-1:0]   STAGE_PC,
  output logic [STAGES-1:0]        STAGE_VALID,
  output logic                     PC_WRITE,
  output logic                     HAZARD,
  output logic [31:0]              RETIRED
);

  localparam logic [6:0] OpLoad = 7'b0000011;

  logic [XLEN-1:0]   r_ir [STAGES];
  logic [XLEN-1:0]   r_pc [STAGES];
  logic [STAGES-1:0] r_valid;
  logic [31:0]       r_retired;

  logic [XLEN-1:0]   w_ir_d [STAGES];
  logic [XLEN-1:0]   w_pc_d [STAGES];
  logic [STAGES-1:0] w_valid_d;
  logic              w_hazard;
  logic              w_stall;
  logic [4:0]        w_ld_rd;

  // Load in stage 1 whose destination feeds a source of the instruction in stage 0
  always_comb begin
    w_ld_rd  = r_ir[1][11:7];
    w_hazard = ~RST & r_valid[0] & r_valid[1] & (r_ir[1][6:0] == OpLoad) &
               (w_ld_rd != 5'd0) &
               ((w_ld_rd == r_ir[0][19:15]) | (w_ld_rd == r_ir[0][24:20]));
    w_stall  = w_hazard | STALL_REQ;
  end

  // Fetch may move unless frozen, reset or stalled; a flush overrides the stall
  always_comb begin
    HAZARD   = w_hazard;
    PC_WRITE = ~RST & ~FREEZE & (FLUSH | ~w_stall);
  end

  // Next stage contents for an unfrozen edge: advance, then overlay flush or stall
  always_comb begin
    w_ir_d[0]    = IF_VALID ? IF_IR : NOP;
    w_pc_d[0]    = IF_VALID ? IF_PC : '0;
    w_valid_d[0] = IF_VALID;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_ir_d[k]    = r_ir[k-1];
      w_pc_d[k]    = r_pc[k-1];
      w_valid_d[k] = r_valid[k-1];
    end
    if (FLUSH) begin
      for (int unsigned k = 0; k <= FLUSH_STAGE; k++) begin
        w_ir_d[k]    = NOP;
        w_pc_d[k]    = '0;
        w_valid_d[k] = 1'b0;
      end
    end else if (w_stall) begin
      // Decode holds its instruction; a bubble goes down the pipe behind it
      w_ir_d[0]    = r_ir[0];
      w_pc_d[0]    = r_pc[0];
      w_valid_d[0] = r_valid[0];
      w_ir_d[1]    = NOP;
      w_pc_d[1]    = '0;
      w_valid_d[1] = 1'b0;
    end
  end

  // Stage registers and retire counter; FREEZE holds everything
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_ir[k] <= NOP;
        r_pc[k] <= '0;
      end
      r_valid   <= '0;
      r_retired <= '0;
    end else if (!FREEZE) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_ir[k] <= w_ir_d[k];
        r_pc[k] <= w_pc_d[k];
      end
      r_valid <= w_valid_d;
      if (r_valid[STAGES-1]) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  // Pack per-stage state onto the flat output buses
  always_comb begin
    STAGE_IR = '0;
    STAGE_PC = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      STAGE_IR[k*XLEN +: XLEN] = r_ir[k];
      STAGE_PC[k*XLEN +: XLEN] = r_pc[k];
    end
    STAGE_VALID = r_valid;
    RETIRED     = r_retired;
  end

endmodule

// File: doc/pipe_track.md
PIPE_TRACK -- requirements
Module: pipe_track

Interface
REQ-001 Parameter XLEN, default 32, instruction and PC width.
REQ-002 Parameter STAGES, default 4, number of tracked stages after fetch; stage 0 = decode, stage STAGES-1 = writeback; legal range 3..8.
REQ-003 Parameter FLUSH_STAGE, default 1, stage index where control transfers resolve; legal range 1..STAGES-2.
REQ-004 Parameter NOP, default 32'h00000013, instruction word loaded into a stage holding a bubble.
REQ-005 One clock, CLK; reset RST is asynchronous and active-high.
REQ-006 CLK  in  1  rising-edge clock.
REQ-007 RST  in  1  asynchronous active-high reset.
REQ-008 IF_IR  in  XLEN  fetched instruction.
REQ-009 IF_PC  in  XLEN  PC of IF_IR.
REQ-010 IF_VALID  in  1  IF_IR/IF_PC valid this cycle.
REQ-011 FREEZE  in  1  global hold, e.g. memory busy.
REQ-012 FLUSH  in  1  taken control transfer resolved in stage FLUSH_STAGE.
REQ-013 STALL_REQ  in  1  external decode stall request.
REQ-014 STAGE_IR  out  STAGES*XLEN  per-stage instruction, stage k at bits [k*XLEN +: XLEN].
REQ-015 STAGE_PC  out  STAGES*XLEN  per-stage PC, same packing.
REQ-016 STAGE_VALID  out  STAGES  per-stage valid bit.
REQ-017 PC_WRITE  out  1  fetch PC may update this cycle.
REQ-018 HAZARD  out  1  internal load-use stall active.
REQ-019 RETIRED  out  32  count of valid instructions leaving stage STAGES-1.

Function
REQ-020 Load-use hazard (combinational) SHALL be: VALID[0] & VALID[1] & IR1[6:0]==7'b0000011 & IR1[11:7]!=0 & (IR1[11:7]==IR0[19:15] | IR1[11:7]==IR0[24:20]); HAZARD SHALL equal it.
REQ-021 stall SHALL = HAZARD | STALL_REQ.
REQ-022 Per-edge priority SHALL be RST > FREEZE > FLUSH > stall > advance.
REQ-023 FREEZE=1: all stage registers and RETIRED hold; PC_WRITE=0; a FLUSH asserted during FREEZE is ignored and the requester holds it until FREEZE drops.
REQ-024 Advance: stage k>0 loads stage k-1 (IR, PC, VALID); stage 0 loads IF_IR, IF_PC, VALID=IF_VALID; if IF_VALID=0, stage 0 IR=NOP.
REQ-025 FLUSH (FREEZE=0): stages 0..FLUSH_STAGE load IR=NOP, PC=0, VALID=0; stages >FLUSH_STAGE advance normally; stall is ignored.
REQ-026 Stall (FREEZE=0, FLUSH=0): stage 0 holds; stage 1 loads bubble (NOP, PC=0, VALID=0); stages >=2 advance.
REQ-027 PC_WRITE SHALL = ~RST & ~FREEZE & (FLUSH | ~stall), combinational, same cycle.
REQ-028 RETIRED SHALL increment by 1 on each edge with FREEZE=0 and VALID[STAGES-1]=1, wrapping from 2^32-1 to 0.
REQ-029 Latency: an instruction accepted at edge n SHALL appear in stage k after edge n+k absent stalls, freezes and flushes.
REQ-030 Bubbles SHALL never trigger HAZARD or increment RETIRED.
REQ-031 IR/PC of an invalid stage SHALL always read NOP/0.

Reset
REQ-032 RST=1 SHALL immediately and asynchronously force every stage to IR=NOP, PC=0, VALID=0, and RETIRED=0.
REQ-033 While RST=1, PC_WRITE SHALL be 0 and HAZARD SHALL be 0.
REQ-034 Reset asserted mid-stall, mid-flush or mid-freeze SHALL discard all in-flight state; the first edge after release SHALL behave as REQ-024.

Verification
REQ-035 Streaming: 6 valid instructions PC 0,4,...,20, no stalls -> PC 0 in stage 3 after edge 4; RETIRED=2 after edge 6.
REQ-036 Load-use: stage1=lw x5 (0x0002A283), stage0=add x6,x5,x1 -> HAZARD=1, PC_WRITE=0 for one cycle; next edge stage1 bubble, stage0 unchanged; rd=x0 load -> HAZARD=0.
REQ-037 Flush: FLUSH=1 with stages valid PCs 12,8,4,0 -> after edge stages 0,1 invalid/NOP, stage2 PC=8, stage3 PC=4, PC_WRITE=1 during the flush cycle.
REQ-038 Priority: FLUSH, STALL_REQ and FREEZE together -> nothing changes; drop FREEZE, keep FLUSH -> flush applies, stall ignored.
REQ-039 Counter wrap: RETIRED preloaded to 0xFFFFFFFF via run, valid retire -> 0; bubble retire -> no change.
REQ-040 Async reset: assert RST between edges mid-stall -> outputs cleared before next edge, RETIRED=0.
